// File: rtl/bist_pkg.sv
// Shared widths, default terminal counts and start-edge codes for the BIST
// counting datapath and the controller that consumes it.
package bist_pkg;

    localparam int CNT_M_W      = 4;
    localparam int CNT_N_W      = 3;
    localparam int START_HIST_W = 2;

    localparam int M_TERM_DEFAULT = 9;
    localparam int N_TERM_DEFAULT = 4;

    // start_val patterns that the controller reads as edges of the start request
    localparam logic [START_HIST_W-1:0] START_RISE = 2'b01;
    localparam logic [START_HIST_W-1:0] START_FALL = 2'b10;

    // True when a terminal count is representable in a counter of the given width
    function automatic bit term_fits(input int term, input int width);
        return (term >= 0) && (term <= (1 << width) - 1);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Enable-gated modulo counter: counts 0..TERM and wraps, flagging the wrap
// cycle on a combinational carry so an outer counter can be chained externally.
module mod_counter
    import bist_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TERM  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

    generate
        if (!term_fits(TERM, WIDTH)) begin : g_bad_term
            $fatal(1, "mod_counter: TERM does not fit in WIDTH bits");
        end
    endgenerate

    logic at_term;

    assign at_term = (count == TERM_V);

    // Carry marks the cycle whose edge performs the wrap; reset masks it so the
    // controller never sees a spurious carry while the block is being cleared.
    assign carry_out = enable & at_term & ~reset;

    // Reset beats enable; an enabled counter at terminal wraps, otherwise it steps or holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (at_term) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_counter_sync.sv
// Counting and start-conditioning datapath for the BIST controller: an inner
// pattern counter, an outer iteration counter and a two-deep start history.
// Nesting of the counters is left to the external FSM.
module bist_counter_sync
    import bist_pkg::*;
#(
    parameter int M_TERM = M_TERM_DEFAULT,
    parameter int N_TERM = N_TERM_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    enable_count_M,
    input  logic                    enable_count_N,
    output logic [CNT_M_W-1:0]      count_M,
    output logic [CNT_N_W-1:0]      count_N,
    output logic                    carry_out_M,
    output logic                    carry_out_N,
    output logic [START_HIST_W-1:0] start_val
);

    generate
        if (!term_fits(M_TERM, CNT_M_W)) begin : g_bad_m_term
            $fatal(1, "bist_counter_sync: M_TERM must be in 0..15");
        end
        if (!term_fits(N_TERM, CNT_N_W)) begin : g_bad_n_term
            $fatal(1, "bist_counter_sync: N_TERM must be in 0..7");
        end
    endgenerate

    mod_counter #(
        .WIDTH (CNT_M_W),
        .TERM  (M_TERM)
    ) u_count_m (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable_count_M),
        .count     (count_M),
        .carry_out (carry_out_M)
    );

    mod_counter #(
        .WIDTH (CNT_N_W),
        .TERM  (N_TERM)
    ) u_count_n (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable_count_N),
        .count     (count_N),
        .carry_out (carry_out_N)
    );

    // Shift the raw start request through two flops; the first stage also
    // resynchronises it, and the pair gives the controller its edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_val <= '0;
        end else begin
            start_val <= {start_val[0], start};
        end
    end

endmodule

// File: tb/tb_bist_counter_sync.sv
// Scoreboard bench for bist_counter_sync: a driver applies directed and random
// stimulus each cycle and queues the expected outputs from a behavioural model;
// an independent monitor pops and compares once per cycle.
`timescale 1ns/1ps
module tb_bist_counter_sync;

    localparam int M_TERM = 9;
    localparam int N_TERM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       enable_count_M;
    logic       enable_count_N;
    logic [3:0] count_M;
    logic [2:0] count_N;
    logic       carry_out_M;
    logic       carry_out_N;
    logic [1:0] start_val;

    typedef struct {
        logic [3:0] cm;
        logic [2:0] cn;
        logic [1:0] sv;
        logic       cym;
        logic       cyn;
    } expect_t;

    expect_t sb_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural reference state
    int   mdl_m     = 0;
    int   mdl_n     = 0;
    int   mdl_sv    = 0;
    bit   mdl_known = 0;

    bist_counter_sync #(
        .M_TERM (M_TERM),
        .N_TERM (N_TERM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .enable_count_M (enable_count_M),
        .enable_count_N (enable_count_N),
        .count_M        (count_M),
        .count_N        (count_N),
        .carry_out_M    (carry_out_M),
        .carry_out_N    (carry_out_N),
        .start_val      (start_val)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, queue what the outputs
    // must show during this cycle, then advance the model past the next edge.
    task automatic applyStimulus(input bit rst, input bit en_m, input bit en_n,
                                 input bit st, input bit glitch, input bit tie_n);
        bit      cy_m;
        bit      cy_n;
        bit      en_n_eff;
        bit      st_eff;
        expect_t e;
        @(negedge clk);
        cy_m     = en_m && !rst && (mdl_m == M_TERM);
        en_n_eff = tie_n ? cy_m : en_n;
        cy_n     = en_n_eff && !rst && (mdl_n == N_TERM);
        st_eff   = glitch ? 1'b0 : st;
        reset          = rst;
        enable_count_M = en_m;
        enable_count_N = en_n_eff;
        start          = glitch ? 1'b1 : st;
        if (mdl_known) begin
            e.cm  = 4'(mdl_m);
            e.cn  = 3'(mdl_n);
            e.sv  = 2'(mdl_sv);
            e.cym = cy_m;
            e.cyn = cy_n;
            sb_q.push_back(e);
        end
        if (rst) begin
            mdl_known = 1;
            mdl_m  = 0;
            mdl_n  = 0;
            mdl_sv = 0;
        end else begin
            if (en_m)     mdl_m = (mdl_m == M_TERM) ? 0 : mdl_m + 1;
            if (en_n_eff) mdl_n = (mdl_n == N_TERM) ? 0 : mdl_n + 1;
            mdl_sv = ((mdl_sv * 2) % 4) + int'(st_eff);
        end
        if (glitch) begin
            #1 start = 1'b0;
        end
    endtask

    // Monitor: one expected record per cycle, compared shortly after the falling edge
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("count_M",     8'(count_M),     8'(e.cm));
                checkOutput("count_N",     8'(count_N),     8'(e.cn));
                checkOutput("start_val",   8'(start_val),   8'(e.sv));
                checkOutput("carry_out_M", 8'(carry_out_M), 8'(e.cym));
                checkOutput("carry_out_N", 8'(carry_out_N), 8'(e.cyn));
            end
        end
    end

    initial begin
        bit tie;
        reset          = 1'b0;
        start          = 1'b0;
        enable_count_M = 1'b0;
        enable_count_N = 1'b0;

        $display("[TB] reset with enables and start high");
        repeat (2) applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] M full sequence");
        repeat (12) applyStimulus(0, 1, 0, 0, 0, 0);

        $display("[TB] nested counters");
        repeat (50) applyStimulus(0, 1, 0, 0, 0, 1);

        $display("[TB] hold and reset priority");
        for (int i = 0; i < 20 && mdl_m != 5; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && mdl_m != 7; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] enable dropped at terminal");
        for (int i = 0; i < 20 && mdl_m != M_TERM; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);

        $display("[TB] start history and glitch");
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        tie = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) tie = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, tie);
        end

        repeat (3) @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending records, expected 0", sb_q.size());
        end
        if (n_compared < 12) begin
            n_mismatched++;
            $display("[TB] FAIL coverage: got %0d comparisons, expected at least 12", n_compared);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bist_counter_sync.md
# bist_counter_sync

Counting and input-conditioning datapath for the BIST controller. It contains two enable-gated modulo counters:
- an inner 4-bit pattern counter (M);
- an outer 3-bit iteration counter (N).

It also holds a 2-stage shift register that samples the asynchronous `start` request for the controller's edge detection. The block has no state machine: `enable_count_M` and `enable_count_N` are driven by the external BIST FSM, and carries and `start_val` are returned to that FSM.

## Interface
- `M_TERM`, default 9: terminal value of `count_M`. Legal range 0..15, giving a count sequence 0..M_TERM.
- `N_TERM`, default 4: terminal value of `count_N`. Legal range 0..7, giving a count sequence 0..N_TERM.

One clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high. Clears all state.
- `start`  in  1  raw start request. May be asynchronous to `clk` and may bounce.
- `enable_count_M`  in  1  advance the M counter this cycle.
- `enable_count_N`  in  1  advance the N counter this cycle.
- `count_M`  out  4  current inner count.
- `count_N`  out  3  current outer count.
- `carry_out_M`  out  1  M counter at terminal and enabled (combinational).
- `carry_out_N`  out  1  N counter at terminal and enabled (combinational).
- `start_val`  out  2  sampled start history. Bit 0 is `start` delayed 1 cycle; bit 1 is `start` delayed 2 cycles.

## Operation
- **Counter update.** Each counter updates on the rising edge of `clk`, with this priority:
  - `reset`: count goes to 0;
  - else enable=1 and count==TERM: count goes to 0 (wrap);
  - else enable=1: count goes to count+1;
  - else: hold.
- **Carry.** `carry_out_X` = enable_X & (count_X == X_TERM) & ~reset.
  - Purely combinational; asserted during the cycle whose edge performs the wrap.
- **Independence.** The counters are independent; there is no internal chaining. The FSM is expected to drive `enable_count_N = carry_out_M` when nesting. Both counters enabled in the same cycle is legal; each behaves per its own rule.
- **Shift register.** On each edge, `start_val` goes to {start_val[0], start}. `reset` forces 2'b00.
- **Edge qualification.** Consumers treat `start_val == 2'b01` as a qualified rising edge and `2'b10` as a falling edge. The block itself performs no edge decision.
- **Arithmetic.** Unsigned, fixed widths (4 and 3 bits). Values above TERM are unreachable from reset.
- **Elaboration checks.** M_TERM ≤ 15 and N_TERM ≤ 7, checked at elaboration (fatal on violation).

## Timing
- **Reset values.** `count_M` = 0, `count_N` = 0, `start_val` = 2'b00, both carries = 0.
  - These values appear after the first edge with reset=1.
  - Carries are 0 for the entire time reset is high.
- **Counter latency.** 1 cycle from enable sampled high to the count change.
- **Carry latency.** 0 cycles from count/enable to carry.
- **`start` latency.** 1 edge to `start_val[0]`, 2 edges to `start_val[1]`.
- **Reset mid-count.** Any count returns to 0 on that edge, regardless of enable.
- **Enable dropped at terminal.** The counter holds TERM and carry is 0. Re-asserting enable produces carry and a wrap on the next edge.
- **Glitches on `start`.** A `start` pulse shorter than one clock period, falling between edges, is not captured.

## Structure
- **Package `bist_pkg`.** Holds:
  - width constants: CNT_M_W = 4, CNT_N_W = 3, START_HIST_W = 2;
  - default terminals;
  - localparams for the edge codes: START_RISE = 2'b01, START_FALL = 2'b10.
- **Sub-module `mod_counter`.** A single parameterized counter (WIDTH, TERM; ports clk, reset, enable, count, carry_out), instantiated twice: M as WIDTH 4 and N as WIDTH 3.
- **Shift register.** Implemented inline in the top.

## Test plan
- **Reset.** Hold reset 2 cycles with enables=1 and start=1 → `count_M` = 0, `count_N` = 0, `start_val` = 00, carries 0 throughout.
- **M full sequence.** `enable_count_M` = 1 for 12 cycles → `count_M` runs 0..9, 0, 1. `carry_out_M` is high only while `count_M` = 9.
- **Nested operation.** Tie `enable_count_N` = `carry_out_M` and run 50 cycles → `count_N` increments once per 10 cycles. `carry_out_N` pulses at `count_N` = 4 with `count_M` = 9, and both counters are then 0.
- **Hold and reset priority.** Deassert enable at `count_M` = 5 → holds 5 with carry 0. Assert reset with enable=1 at `count_M` = 7 → `count_M` = 0 next edge.
- **Start history.** Drive start 0,1,1,0 on successive cycles → `start_val` sequence 00, 01, 11, 10.
- **Start glitch.** A 1 ns start glitch between edges → `start_val` stays 00.
